// File: rtl/gate_frame_dispatcher_pkg.sv
// Shared definitions for the gate frame dispatcher: command word fields, opcodes,
// FSM state encoding and default timing values.
package gate_frame_dispatcher_pkg;

    localparam int DEF_N_MOD      = 9;
    localparam int DEF_SHOOT_W    = 48;
    localparam int DEF_GUARD      = 96;
    localparam int DEF_START_WIN  = 4;
    localparam int DEF_TX_TIMEOUT = 65535;

    localparam logic [3:0] OP_WRITE  = 4'h0;
    localparam logic [3:0] OP_COMMIT = 4'hF;

    localparam int CMD_IDX_LSB  = 12;
    localparam int CMD_OP_LSB   = 8;
    localparam int CMD_DATA_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LAUNCH     = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_GUARD      = 3'd4,
        ST_SHOOT      = 3'd5
    } state_e;

    function automatic logic [3:0] cmd_idx(input logic [15:0] w);
        return w[CMD_IDX_LSB +: 4];
    endfunction

    function automatic logic [3:0] cmd_op(input logic [15:0] w);
        return w[CMD_OP_LSB +: 4];
    endfunction

    function automatic logic [7:0] cmd_data(input logic [15:0] w);
        return w[CMD_DATA_LSB +: 8];
    endfunction

endpackage

// File: rtl/gate_frame_dispatcher_cycle_counter.sv
// Loadable down-counter with a zero flag; it holds at zero until reloaded,
// so one instance can time every interval of the dispatcher in turn.
module cycle_counter
    import gate_frame_dispatcher_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/gate_frame_dispatcher.sv
// Collects gate bytes from SPI command words into a shadow bank, broadcasts them to
// the UART transmitters on COMMIT, then fires one shoot pulse after a guard time.
module gate_frame_dispatcher
    import gate_frame_dispatcher_pkg::*;
#(
    parameter int N_MOD      = DEF_N_MOD,
    parameter int SHOOT_W    = DEF_SHOOT_W,
    parameter int GUARD      = DEF_GUARD,
    parameter int START_WIN  = DEF_START_WIN,
    parameter int TX_TIMEOUT = DEF_TX_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [15:0]        cmd_word,
    input  logic [N_MOD-1:0]   tx_busy,
    input  logic               clear_err,
    output logic [N_MOD-1:0]   start_tx,
    output logic [8*N_MOD-1:0] data_to_tx,
    output logic               shoot,
    output logic               busy,
    output logic               frame_done,
    output logic               err_index,
    output logic               err_overrun,
    output logic               err_timeout
);

    localparam int CW = $clog2(TX_TIMEOUT + 1);

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n_int;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n_int  = rst_sync_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= rst_sync_d;
    end

    logic [3:0] op, idx;
    logic [7:0] gate_byte;
    logic       is_write, is_commit, idx_bad;

    assign op        = cmd_op(cmd_word);
    assign idx       = cmd_idx(cmd_word);
    assign gate_byte = cmd_data(cmd_word);
    assign is_write  = cmd_valid && (op == OP_WRITE);
    assign is_commit = cmd_valid && (op == OP_COMMIT);
    assign idx_bad   = int'(idx) >= N_MOD;

    state_e             state_q, state_d;
    logic [8*N_MOD-1:0] shadow_q, shadow_d;
    logic [8*N_MOD-1:0] data_q, data_d;
    logic [N_MOD-1:0]   start_tx_q, start_tx_d;
    logic               shoot_q, shoot_d;
    logic               frame_done_q, frame_done_d;
    logic               err_index_q, err_index_d;
    logic               err_overrun_q, err_overrun_d;
    logic               err_timeout_q, err_timeout_d;
    logic               timeout_set;
    logic               cnt_load, cnt_zero;
    logic [CW-1:0]      cnt_val;

    cycle_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n_int),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_comb begin
        shadow_d = shadow_q;
        if (is_write && !idx_bad) begin
            for (int i = 0; i < N_MOD; i++) begin
                if (int'(idx) == i) shadow_d[8*i +: 8] = gate_byte;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        start_tx_d   = '0;
        data_d       = data_q;
        frame_done_d = 1'b0;
        timeout_set  = 1'b0;
        cnt_load     = 1'b0;
        cnt_val      = '0;
        case (state_q)
            ST_IDLE: begin
                if (is_commit) begin
                    state_d    = ST_LAUNCH;
                    start_tx_d = '1;
                    data_d     = shadow_q;
                    cnt_load   = 1'b1;
                end
            end
            ST_LAUNCH: begin
                state_d  = ST_WAIT_START;
                cnt_load = 1'b1;
                cnt_val  = CW'(START_WIN - 1);
            end
            ST_WAIT_START: begin
                if (&tx_busy) begin
                    state_d  = ST_WAIT_DONE;
                    cnt_load = 1'b1;
                    cnt_val  = CW'(TX_TIMEOUT - 1);
                end else if (cnt_zero) begin
                    state_d     = ST_IDLE;
                    timeout_set = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_busy == '0) begin
                    state_d  = ST_GUARD;
                    cnt_load = 1'b1;
                    cnt_val  = CW'(GUARD - 1);
                end else if (cnt_zero) begin
                    state_d     = ST_IDLE;
                    timeout_set = 1'b1;
                end
            end
            ST_GUARD: begin
                if (cnt_zero) begin
                    state_d  = ST_SHOOT;
                    cnt_load = 1'b1;
                    cnt_val  = CW'(SHOOT_W - 1);
                end
            end
            ST_SHOOT: begin
                if (cnt_zero) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Registering the decoded next state keeps shoot free of decode glitches.
        shoot_d = (state_d == ST_SHOOT);
    end

    // A new error in the same cycle as clear_err keeps the flag set.
    always_comb begin
        err_index_d   = clear_err ? 1'b0 : err_index_q;
        err_overrun_d = clear_err ? 1'b0 : err_overrun_q;
        err_timeout_d = clear_err ? 1'b0 : err_timeout_q;
        if (is_write && idx_bad)              err_index_d   = 1'b1;
        if (is_commit && state_q != ST_IDLE)  err_overrun_d = 1'b1;
        if (timeout_set)                      err_timeout_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q       <= ST_IDLE;
            shadow_q      <= '0;
            data_q        <= '0;
            start_tx_q    <= '0;
            shoot_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            err_index_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            data_q        <= data_d;
            start_tx_q    <= start_tx_d;
            shoot_q       <= shoot_d;
            frame_done_q  <= frame_done_d;
            err_index_q   <= err_index_d;
            err_overrun_q <= err_overrun_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign start_tx    = start_tx_q;
    assign data_to_tx  = data_q;
    assign shoot       = shoot_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = frame_done_q;
    assign err_index   = err_index_q;
    assign err_overrun = err_overrun_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_gate_frame_dispatcher.sv
// Self-checking bench for gate_frame_dispatcher: vector table for command decoding,
// hand sequences for timeouts/overrun/reset, and randomized frames against a model.
module tb_gate_frame_dispatcher;
    import gate_frame_dispatcher_pkg::*;

    localparam int N    = 9;
    localparam int SW   = 48;
    localparam int GD   = 96;
    localparam int SWIN = 4;
    localparam int TO   = 200;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           cmd_valid = 1'b0;
    logic [15:0]    cmd_word = '0;
    logic [N-1:0]   tx_busy = '0;
    logic           clear_err = 1'b0;
    logic [N-1:0]   start_tx;
    logic [8*N-1:0] data_to_tx;
    logic           shoot, busy, frame_done, err_index, err_overrun, err_timeout;

    gate_frame_dispatcher #(
        .N_MOD(N), .SHOOT_W(SW), .GUARD(GD), .START_WIN(SWIN), .TX_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_word(cmd_word),
        .tx_busy(tx_busy), .clear_err(clear_err), .start_tx(start_tx),
        .data_to_tx(data_to_tx), .shoot(shoot), .busy(busy), .frame_done(frame_done),
        .err_index(err_index), .err_overrun(err_overrun), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // UART model modes: 0 normal, 1 busy stuck high, 2 busy never asserts.
    int mode [N];
    int len  [N];
    int rem  [N];

    int             start_cnt = 0, start_cyc = 0, shoot_rise_cnt = 0, rise_cyc = 0;
    int             run_len = 0, last_width = 0, fd_cnt = 0, last_fall = 0, to_rise_cyc = 0;
    logic [N-1:0]   start_val = '0;
    logic [8*N-1:0] start_data = '0;
    logic           shoot_prev = 1'b0, to_prev = 1'b0;

    logic [7:0] m_shadow [N];
    logic       m_err;
    int         commit_cyc = 0;

    always @(negedge clk) begin
        if (start_tx != '0) begin
            start_cnt  = start_cnt + 1;
            start_val  = start_tx;
            start_data = data_to_tx;
            start_cyc  = cyc;
        end
        if (shoot && !shoot_prev) begin
            shoot_rise_cnt = shoot_rise_cnt + 1;
            rise_cyc       = cyc;
            run_len        = 0;
        end
        if (shoot) run_len = run_len + 1;
        if (!shoot && shoot_prev) last_width = run_len;
        shoot_prev = shoot;
        if (frame_done) fd_cnt = fd_cnt + 1;
        if (err_timeout && !to_prev) to_rise_cyc = cyc;
        to_prev = err_timeout;
        for (int i = 0; i < N; i++) begin
            if (start_tx[i]) begin
                if (mode[i] != 2) begin
                    tx_busy[i] = 1'b1;
                    rem[i]     = len[i];
                end
            end else if (tx_busy[i] && mode[i] != 1) begin
                rem[i] = rem[i] - 1;
                if (rem[i] <= 0) begin
                    tx_busy[i] = 1'b0;
                    last_fall  = cyc;
                end
            end
        end
    end

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic check_vec(input string name, input logic [8*N-1:0] act, input logic [8*N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8*N-1:0] pack_shadow();
        logic [8*N-1:0] p;
        for (int i = 0; i < N; i++) p[8*i +: 8] = m_shadow[i];
        return p;
    endfunction

    task automatic send(input logic vld, input logic [3:0] op, input logic [3:0] idx,
                        input logic [7:0] d, input logic clr);
        @(negedge clk);
        cmd_valid = vld;
        cmd_word  = {idx, op, d};
        clear_err = clr;
        if (vld && op == OP_COMMIT) commit_cyc = cyc;
        if (vld && op == OP_WRITE && int'(idx) < N) m_shadow[idx] = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_word  = '0;
        clear_err = 1'b0;
    endtask

    task automatic wait_frame_done(input int f0, input int limit);
        int n;
        n = 0;
        while (fd_cnt == f0 && n < limit) begin
            @(negedge clk); #1;
            n++;
        end
        check_int("frame_done_seen", int'(fd_cnt > f0), 1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || tx_busy != '0) && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        check_int(name, int'(busy || tx_busy != '0), 0);
    endtask

    task automatic run_frame(input logic [8*N-1:0] exp_data);
        int s0, r0, f0;
        s0 = start_cnt; r0 = shoot_rise_cnt; f0 = fd_cnt;
        send(1'b1, OP_COMMIT, 4'h0, 8'h00, 1'b0);
        wait_frame_done(f0, 600);
        repeat (3) @(negedge clk);
        #1;
        check_int("start_count", start_cnt - s0, 1);
        check_int("start_value", int'(start_val), int'({N{1'b1}}));
        check_int("start_latency", start_cyc - commit_cyc, 1);
        check_vec("launch_data", start_data, exp_data);
        check_int("shoot_count", shoot_rise_cnt - r0, 1);
        check_int("shoot_width", last_width, SW);
        check_int("shoot_delay", rise_cyc - last_fall, GD + 1);
        check_int("frame_done_count", fd_cnt - f0, 1);
        check_int("busy_after_frame", int'(busy), 0);
    endtask

    typedef struct packed {
        logic       vld;
        logic [3:0] op;
        logic [3:0] idx;
        logic [7:0] d;
        logic       clr;
        logic       exp_err;
    } vec_t;

    vec_t vt [15];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, s0, r0, f0, ncmd;
        logic [3:0] op, idx;
        logic [7:0] d;

        for (int i = 0; i < N; i++) begin
            mode[i] = 0; len[i] = 100; rem[i] = 0; m_shadow[i] = 8'h00;
        end
        m_err = 1'b0;

        for (int r = 0; r < 9; r++)
            vt[r] = '{1'b1, OP_WRITE, 4'(r), 8'((r + 1) * 17), 1'b0, 1'b0};
        vt[9]  = '{1'b1, OP_WRITE, 4'd12, 8'hAB, 1'b0, 1'b1};
        vt[10] = '{1'b1, 4'h5,     4'd2,  8'h77, 1'b0, 1'b1};
        vt[11] = '{1'b0, 4'h0,     4'd0,  8'h00, 1'b1, 1'b0};
        vt[12] = '{1'b1, 4'h3,     4'd13, 8'h42, 1'b0, 1'b0};
        vt[13] = '{1'b1, OP_WRITE, 4'd10, 8'h5A, 1'b1, 1'b1};
        vt[14] = '{1'b0, 4'h0,     4'd0,  8'h00, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_int("rst_start_tx", int'(start_tx), 0);
        check_vec("rst_data_to_tx", data_to_tx, '0);
        check_int("rst_shoot", int'(shoot), 0);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_frame_done", int'(frame_done), 0);
        check_int("rst_errs", int'({err_index, err_overrun, err_timeout}), 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Command decoding table
        for (int r = 0; r < 15; r++) begin
            send(vt[r].vld, vt[r].op, vt[r].idx, vt[r].d, vt[r].clr);
            #1;
            check_int($sformatf("vec%0d_err_index", r), int'(err_index), int'(vt[r].exp_err));
        end

        // Nominal frame
        run_frame(72'h998877665544332211);
        check_int("frame1_errs", int'({err_index, err_overrun, err_timeout}), 0);

        // Overrun: second COMMIT while waiting for the UARTs
        s0 = start_cnt; r0 = shoot_rise_cnt; f0 = fd_cnt;
        send(1'b1, OP_COMMIT, 4'h3, 8'h00, 1'b0);
        repeat (20) @(negedge clk);
        send(1'b1, OP_COMMIT, 4'h0, 8'h00, 1'b0);
        #1;
        check_int("overrun_flag", int'(err_overrun), 1);
        check_int("overrun_busy", int'(busy), 1);
        wait_frame_done(f0, 600);
        repeat (GD + SW + 20) @(negedge clk);
        #1;
        check_int("overrun_starts", start_cnt - s0, 1);
        check_int("overrun_shoots", shoot_rise_cnt - r0, 1);
        check_int("overrun_frame_done", fd_cnt - f0, 1);
        send(1'b0, 4'h0, 4'h0, 8'h00, 1'b1);
        #1;
        check_int("overrun_cleared", int'(err_overrun), 0);

        // Module 4 busy stuck high
        mode[4] = 1;
        r0 = shoot_rise_cnt; f0 = fd_cnt;
        send(1'b1, OP_COMMIT, 4'h0, 8'h00, 1'b0);
        n = 0;
        while (!err_timeout && n < 400) begin @(negedge clk); #1; n++; end
        check_int("stuck_timeout_flag", int'(err_timeout), 1);
        check_range("stuck_timeout_time", to_rise_cyc - start_cyc, TO, TO + 3);
        check_int("stuck_busy", int'(busy), 0);
        mode[4] = 0;
        wait_idle("stuck_release_idle");
        repeat (GD + SW + 10) @(negedge clk);
        #1;
        check_int("stuck_no_shoot", shoot_rise_cnt - r0, 0);
        check_int("stuck_no_frame_done", fd_cnt - f0, 0);
        send(1'b0, 4'h0, 4'h0, 8'h00, 1'b1);
        #1;
        check_int("stuck_cleared", int'(err_timeout), 0);

        // Module 7 busy never asserts
        mode[7] = 2;
        r0 = shoot_rise_cnt; f0 = fd_cnt;
        send(1'b1, OP_COMMIT, 4'h0, 8'h00, 1'b0);
        n = 0;
        while (!err_timeout && n < 50) begin @(negedge clk); #1; n++; end
        check_int("nostart_timeout_flag", int'(err_timeout), 1);
        check_range("nostart_timeout_time", to_rise_cyc - start_cyc, SWIN, SWIN + 2);
        check_int("nostart_busy", int'(busy), 0);
        mode[7] = 0;
        wait_idle("nostart_idle");
        repeat (GD + SW + 10) @(negedge clk);
        #1;
        check_int("nostart_no_shoot", shoot_rise_cnt - r0, 0);
        check_int("nostart_no_frame_done", fd_cnt - f0, 0);
        send(1'b0, 4'h0, 4'h0, 8'h00, 1'b1);
        #1;
        check_int("nostart_cleared", int'(err_timeout), 0);

        // Reset in the 10th shoot cycle
        f0 = fd_cnt;
        send(1'b1, OP_COMMIT, 4'h0, 8'h00, 1'b0);
        n = 0;
        while (!shoot && n < 500) begin @(negedge clk); #1; n++; end
        check_int("midreset_shoot_seen", int'(shoot), 1);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check_int("midreset_shoot_drop", int'(shoot), 0);
        check_int("midreset_start_tx", int'(start_tx), 0);
        check_int("midreset_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < N; i++) m_shadow[i] = 8'h00;
        repeat (5) @(negedge clk);
        #1;
        check_int("midreset_no_frame_done", fd_cnt - f0, 0);
        check_int("midreset_idle", int'(busy), 0);
        send(1'b1, OP_WRITE, 4'd0, 8'hC3, 1'b0);
        send(1'b1, OP_WRITE, 4'd3, 8'h3C, 1'b0);
        send(1'b1, OP_WRITE, 4'd8, 8'hE7, 1'b0);
        run_frame(pack_shadow());

        // Randomized frames against the model
        for (int it = 0; it < 6; it++) begin
            ncmd  = $urandom_range(3, 10);
            m_err = 1'b0;
            for (int k = 0; k < ncmd; k++) begin
                op  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 14)) : OP_WRITE;
                idx = 4'($urandom_range(0, 15));
                d   = 8'($urandom);
                send(1'b1, op, idx, d, 1'b0);
                if (op == OP_WRITE && int'(idx) >= N) m_err = 1'b1;
            end
            #1;
            check_int($sformatf("rand%0d_err_index", it), int'(err_index), int'(m_err));
            for (int i = 0; i < N; i++) len[i] = $urandom_range(5, 60);
            run_frame(pack_shadow());
            send(1'b0, 4'h0, 4'h0, 8'h00, 1'b1);
            #1;
            check_int($sformatf("rand%0d_cleared", it), int'(err_index), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_frame_dispatcher.md
Name: gate_frame_dispatcher

Overview:
- Sits between the SPI slave receiver and the nine uart_tx instances in the FPGA top.
- Collects per-module gate bytes arriving as 16-bit SPI command words into a shadow bank.
- On a commit word, broadcasts all nine bytes in parallel over UART, waits for every transmitter to finish, then emits one shoot pulse to the power modules.
- Flags malformed commands, overruns and stuck UARTs.

Parameters:
- N_MOD, 9, number of UART-connected modules; indices 0..N_MOD-1.
- SHOOT_W, 48, shoot pulse width in clk cycles (1 us at 48 MHz).
- GUARD, 96, idle cycles between last tx_busy fall and shoot rise.
- START_WIN, 4, cycles allowed after launch for all tx_busy to assert.
- TX_TIMEOUT, 65535, cycles allowed for all tx_busy to deassert; counter width is $clog2(TX_TIMEOUT+1).

Ports:
- clk  in  1  system clock, 48 MHz HFOSC.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  one-cycle strobe; cmd_word is valid in this cycle.
- cmd_word  in  16  [15:12] module index, [11:8] opcode, [7:0] gate byte.
- tx_busy  in  N_MOD  per-UART busy, bit i belongs to module i.
- clear_err  in  1  clears sticky error flags.
- start_tx  out  N_MOD  per-UART start strobe.
- data_to_tx  out  8*N_MOD  byte for module i on bits [8i+7:8i].
- shoot  out  1  active-high fire pulse.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after shoot falls.
- err_index, err_overrun, err_timeout  out  1 each  sticky error flags.

Behaviour:
- Reset (async assert, sync deassert internally): the following outputs and registers go to 0:
  - start_tx, data_to_tx, shoot, busy, frame_done, all error flags.
  - Shadow bank, all counters.
  - State goes to IDLE.
- Opcodes:
  - 0x0 WRITE: shadow[index] <= gate byte.
  - 0xF COMMIT: launch a frame.
  - Any other opcode: ignored, no flag.
- WRITE is accepted in any state. It never affects a frame in flight, because data_to_tx is loaded only at launch.
- WRITE with index >= N_MOD: shadow unchanged, err_index set.
- COMMIT in IDLE: transition to LAUNCH on the next cycle. The index field is ignored.
- COMMIT while busy: ignored, err_overrun set, in-flight frame continues.
- A WRITE and a COMMIT cannot arrive in the same cycle (single cmd_valid).
- COMMIT immediately after a WRITE in the previous cycle launches with the new byte.
- States:
  - IDLE: wait for COMMIT.
  - LAUNCH (1 cycle): data_to_tx <= shadow bank; start_tx <= all ones for exactly this cycle; the counter is cleared.
  - WAIT_START: exit to WAIT_DONE once tx_busy == all ones. If START_WIN cycles elapse first, err_timeout is set and the state returns to IDLE with no shoot.
  - WAIT_DONE: exit to GUARD once tx_busy == 0. If TX_TIMEOUT cycles elapse first, err_timeout is set and the state returns to IDLE with no shoot.
  - GUARD: GUARD cycles, then SHOOT.
  - SHOOT: shoot = 1 for exactly SHOOT_W cycles, then IDLE with frame_done = 1 for one cycle.
- shoot is registered and glitch-free. It is asserted only in SHOOT; an aborted frame never fires.
- Latency: COMMIT strobe to start_tx is 1 cycle. Last tx_busy fall to shoot rise is GUARD+1 cycles.
- clear_err clears all three flags. If clear_err and a new error occur in the same cycle, the error wins.
- Reset mid-frame: shoot and start_tx drop asynchronously, and no frame_done is produced.

Decomposition:
- Shared package main.vh holds:
  - Opcode constants OP_WRITE, OP_COMMIT.
  - Field position macros CMD_IDX, CMD_OP, CMD_DATA.
  - State encodings.
  - Default SHOOT_W/GUARD values alongside the existing PIPE_MODE/SEC_x macros.
- One natural sub-module: cycle_counter. It is a loadable down-counter with a zero flag, reused for the START_WIN, TX_TIMEOUT, GUARD and SHOOT_W intervals.

Test Plan:
- WRITE idx0..8 with bytes 0x11..0x99, then COMMIT; bench UART model holds busy 100 cycles.
  - start_tx = 0x1FF for one cycle, data_to_tx = 0x998877665544332211.
  - shoot rises 97 cycles after busy falls and lasts 48 cycles; frame_done pulses once.
- WRITE idx 12 data 0xAB -> err_index = 1, shadow unchanged. clear_err -> flag = 0.
- COMMIT, then a second COMMIT during WAIT_DONE -> err_overrun = 1, exactly one shoot pulse.
- Module 4 tx_busy held high after launch, with TX_TIMEOUT set to 200 -> err_timeout at cycle 200, shoot never asserts, busy = 0.
- Module 7 tx_busy never asserts -> err_timeout after 4 cycles, return to IDLE, no shoot.
- Assert reset in the 10th shoot cycle -> shoot = 0 immediately; after release, state is IDLE and the next COMMIT works normally.
